sobel_frame_arbiter: RTL and testbench
======================================

SOBEL_FRAME_ARBITER -- requirements
Module: sobel_frame_arbiter

Interface
REQ-001 Parameter IN_LEN, default 9: pixel beats forwarded to the filter per granted frame (>=1).
REQ-002 Parameter OUT_LEN, default 1: result beats expected back from the filter per granted frame (>=1).
REQ-003 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-004 i_rst  in  1  reset, asynchronous, active-low.
REQ-005 i_req0_vld  in  1  / i_req0_data  in  24  / o_req0_busy  out  1  requester 0 pixel stream (RGB).
REQ-006 i_req1_vld  in  1  / i_req1_data  in  24  / o_req1_busy  out  1  requester 1 pixel stream.
REQ-007 o_rgb_vld  out  1  / o_rgb_data  out  24  / i_rgb_busy  in  1  pixel stream to filter.
REQ-008 i_result_vld  in  1  / i_result_data  in  24  / o_result_busy  out  1  result stream from filter.
REQ-009 o_rsp0_vld  out  1  / o_rsp0_data  out  24  / i_rsp0_busy  in  1  result stream to requester 0; o_rsp1_* / i_rsp1_busy likewise for requester 1.
REQ-010 o_grant  out  2  one-hot current owner; 00 when idle.
REQ-011 o_frames_done  out  16  count of completed frames, wraps 0xFFFF->0.

Function
REQ-012 A beat transfers on a channel in a cycle where vld=1 and busy=0; all channels obey this.
REQ-013 FSM states IDLE, FEED, DRAIN; one owner per frame; frames never interleave.
REQ-014 IDLE: all requester busy=1, o_rgb_vld=0, o_result_busy=1, o_rsp*_vld=0.
REQ-015 IDLE->FEED when any i_reqN_vld=1; owner = requester named by priority pointer if its vld=1, else the other; o_grant updates on the same edge.
REQ-016 Both vld=1 in IDLE: pointer owner wins; the other waits, no beat lost.
REQ-017 FEED: o_rgb_vld/o_rgb_data = owner's vld/data combinationally; o_reqOwner_busy = i_rgb_busy; non-owner busy=1.
REQ-018 in_cnt counts FEED transfers; after the IN_LEN-th transfer, FEED->DRAIN, or FEED->IDLE if out_cnt already reached OUT_LEN.
REQ-019 In FEED and DRAIN, i_result_* routes to o_rspOwner_*; o_result_busy = i_rspOwner_busy; non-owner o_rsp_vld=0.
REQ-020 out_cnt counts result transfers, saturating at OUT_LEN; once OUT_LEN reached o_result_busy=1 for the rest of the frame.
REQ-021 DRAIN->IDLE on the edge where out_cnt reaches OUT_LEN; same edge: counters clear, pointer moves to the non-owner, o_frames_done increments, o_grant=00.
REQ-022 Passthrough adds zero latency; minimum frame occupancy IN_LEN+1 cycles including the IDLE arbitration cycle.
REQ-023 Results arriving in IDLE are back-pressured (busy=1), never dropped or misrouted.

Reset
REQ-024 While i_rst=0: state IDLE, pointer=requester 0, in_cnt=out_cnt=0, o_grant=00, o_frames_done=0, all outputs per REQ-014.
REQ-025 Reset assertion mid-frame aborts the frame immediately; no partial-frame state survives deassertion.

Structure
REQ-026 Shared package holds the 24-bit pixel typedef, FSM state enum and the requester-count constant (2).
REQ-027 One sub-module natural: sobel_rr_pick (2-way round-robin selector: vld pair + pointer -> one-hot grant).
REQ-028 Counter widths = clog2(max(IN_LEN,OUT_LEN)+1).

Verification
REQ-029 Only req0 sends 9 pixels, filter never busy -> o_rgb carries them in order over 9 cycles, 1 result to rsp0, o_frames_done=1, o_grant back to 00.
REQ-030 Both vld in same cycle after reset -> req0 served first, then req1; rsp1 receives only frame-2 result.
REQ-031 i_rgb_busy=1 for 3 cycles mid-frame -> o_req0_busy=1 those cycles, still exactly 9 transfers, no duplicates.
REQ-032 Result returned before 9th pixel -> routed to owner, FSM goes FEED->IDLE directly after 9th pixel.
REQ-033 i_rsp0_busy=1 while result valid -> o_result_busy=1, result held until busy drops.
REQ-034 i_rst=0 after 4 pixels of frame -> grant 00, counters 0; next frame after reset forwards 9 full pixels; 65536 frames -> o_frames_done wraps to 0.

Source files
------------

// File: rtl/sobel_frame_arbiter_pkg.sv
// Shared types for the two-requester Sobel frame arbiter: pixel word, FSM states,
// requester count and the counter-width helper.
package sobel_frame_arbiter_pkg;

  localparam int NUM_REQ = 2;

  typedef logic [23:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic int cnt_w(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/sobel_rr_pick.sv
// Two-way round-robin pick: the pointed-at requester wins if valid, else the other.
module sobel_rr_pick
  import sobel_frame_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_vld,
  input  logic               i_ptr,
  output logic [NUM_REQ-1:0] o_grant
);

  always_comb begin
    o_grant = '0;
    if (i_vld[i_ptr])       o_grant[i_ptr]  = 1'b1;
    else if (i_vld[~i_ptr]) o_grant[~i_ptr] = 1'b1;
  end

endmodule

// File: rtl/sobel_frame_arbiter.sv
// Frame arbiter: grants one requester a whole frame (IN_LEN pixels out, OUT_LEN
// results back) with zero-latency passthrough in both directions.
module sobel_frame_arbiter
  import sobel_frame_arbiter_pkg::*;
#(
  parameter int IN_LEN  = 9,
  parameter int OUT_LEN = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req0_vld,
  input  pixel_t      i_req0_data,
  output logic        o_req0_busy,
  input  logic        i_req1_vld,
  input  pixel_t      i_req1_data,
  output logic        o_req1_busy,
  output logic        o_rgb_vld,
  output pixel_t      o_rgb_data,
  input  logic        i_rgb_busy,
  input  logic        i_result_vld,
  input  pixel_t      i_result_data,
  output logic        o_result_busy,
  output logic        o_rsp0_vld,
  output pixel_t      o_rsp0_data,
  input  logic        i_rsp0_busy,
  output logic        o_rsp1_vld,
  output pixel_t      o_rsp1_data,
  input  logic        i_rsp1_busy,
  output logic [1:0]  o_grant,
  output logic [15:0] o_frames_done
);

  localparam int            CW       = cnt_w(IN_LEN, OUT_LEN);
  localparam logic [CW-1:0] IN_LAST  = CW'(IN_LEN - 1);
  localparam logic [CW-1:0] OUT_LAST = CW'(OUT_LEN - 1);
  localparam logic [CW-1:0] OUT_MAX  = CW'(OUT_LEN);

  state_e               r_state, w_state_nxt;
  logic                 r_ptr;
  logic [CW-1:0]        r_in_cnt, r_out_cnt;
  logic [NUM_REQ-1:0]   r_grant;
  logic [15:0]          r_frames_done;

  logic [NUM_REQ-1:0]   w_pick;
  logic                 w_owner;
  logic                 w_owner_vld, w_owner_rsp_busy;
  pixel_t               w_owner_data;
  logic                 w_out_done, w_out_fin;
  logic                 w_in_xfer, w_out_xfer, w_start, w_frame_end;

  sobel_rr_pick u_pick (
    .i_vld   ({i_req1_vld, i_req0_vld}),
    .i_ptr   (r_ptr),
    .o_grant (w_pick)
  );

  // grant is only consulted outside IDLE, where it is one-hot
  assign w_owner          = r_grant[1];
  assign w_owner_vld      = w_owner ? i_req1_vld  : i_req0_vld;
  assign w_owner_data     = w_owner ? i_req1_data : i_req0_data;
  assign w_owner_rsp_busy = w_owner ? i_rsp1_busy : i_rsp0_busy;
  assign w_out_done       = (r_out_cnt == OUT_MAX);

  assign o_grant       = r_grant;
  assign o_frames_done = r_frames_done;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_start       = 1'b0;
    w_frame_end   = 1'b0;
    w_in_xfer     = 1'b0;
    w_out_xfer    = 1'b0;
    w_out_fin     = 1'b0;
    o_req0_busy   = 1'b1;
    o_req1_busy   = 1'b1;
    o_rgb_vld     = 1'b0;
    o_rgb_data    = w_owner_data;
    o_result_busy = 1'b1;
    o_rsp0_vld    = 1'b0;
    o_rsp1_vld    = 1'b0;
    o_rsp0_data   = i_result_data;
    o_rsp1_data   = i_result_data;

    if (r_state == FEED) begin
      o_rgb_vld = w_owner_vld;
      if (w_owner) o_req1_busy = i_rgb_busy;
      else         o_req0_busy = i_rgb_busy;
      w_in_xfer = w_owner_vld & ~i_rgb_busy;
    end

    // result path stays open until OUT_LEN results have been taken
    if ((r_state == FEED || r_state == DRAIN) && !w_out_done) begin
      o_result_busy = w_owner_rsp_busy;
      if (w_owner) o_rsp1_vld = i_result_vld;
      else         o_rsp0_vld = i_result_vld;
      w_out_xfer = i_result_vld & ~w_owner_rsp_busy;
    end
    w_out_fin = w_out_done | (w_out_xfer & (r_out_cnt == OUT_LAST));

    case (r_state)
      IDLE: begin
        if (|w_pick) begin
          w_state_nxt = FEED;
          w_start     = 1'b1;
        end
      end
      FEED: begin
        if (w_in_xfer && r_in_cnt == IN_LAST) begin
          if (w_out_fin) begin
            w_state_nxt = IDLE;
            w_frame_end = 1'b1;
          end else begin
            w_state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (w_out_fin) begin
          w_state_nxt = IDLE;
          w_frame_end = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_ptr         <= 1'b0;
      r_grant       <= '0;
      r_in_cnt      <= '0;
      r_out_cnt     <= '0;
      r_frames_done <= '0;
    end else begin
      if (w_start) r_grant <= w_pick;
      if (w_frame_end) begin
        r_in_cnt      <= '0;
        r_out_cnt     <= '0;
        r_ptr         <= ~w_owner;
        r_grant       <= '0;
        r_frames_done <= r_frames_done + 16'd1;
      end else begin
        if (w_in_xfer)  r_in_cnt  <= r_in_cnt + CW'(1);
        if (w_out_xfer) r_out_cnt <= r_out_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sobel_frame_arbiter.sv
// Scoreboard bench for sobel_frame_arbiter: queue-driven requesters/filter,
// negedge monitor pops expected pixels and results.
module tb_sobel_frame_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_req0_vld = 1'b0, i_req1_vld = 1'b0;
  logic [23:0] i_req0_data = '0, i_req1_data = '0;
  logic        o_req0_busy, o_req1_busy;
  logic        o_rgb_vld;
  logic [23:0] o_rgb_data;
  logic        i_rgb_busy = 1'b0;
  logic        i_result_vld = 1'b0;
  logic [23:0] i_result_data = '0;
  logic        o_result_busy;
  logic        o_rsp0_vld, o_rsp1_vld;
  logic [23:0] o_rsp0_data, o_rsp1_data;
  logic        i_rsp0_busy = 1'b0, i_rsp1_busy = 1'b0;
  logic [1:0]  o_grant;
  logic [15:0] o_frames_done;

  sobel_frame_arbiter #(.IN_LEN(9), .OUT_LEN(1)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req0_vld(i_req0_vld), .i_req0_data(i_req0_data), .o_req0_busy(o_req0_busy),
    .i_req1_vld(i_req1_vld), .i_req1_data(i_req1_data), .o_req1_busy(o_req1_busy),
    .o_rgb_vld(o_rgb_vld), .o_rgb_data(o_rgb_data), .i_rgb_busy(i_rgb_busy),
    .i_result_vld(i_result_vld), .i_result_data(i_result_data), .o_result_busy(o_result_busy),
    .o_rsp0_vld(o_rsp0_vld), .o_rsp0_data(o_rsp0_data), .i_rsp0_busy(i_rsp0_busy),
    .o_rsp1_vld(o_rsp1_vld), .o_rsp1_data(o_rsp1_data), .i_rsp1_busy(i_rsp1_busy),
    .o_grant(o_grant), .o_frames_done(o_frames_done)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0, failures = 0;
  logic [23:0] src0[$], src1[$], res_q[$];
  logic [23:0] exp_rgb[$], exp_rsp0[$], exp_rsp1[$];
  bit          res_en = 1'b0;
  int          rgb_cnt = 0, cyc = 0, first_cyc = -1, last_cyc = -1;
  logic [23:0] mon_e;

  // sources: present queue head, advance after an observed handshake
  initial begin
    bit x0, x1, xr;
    forever begin
      @(negedge i_clk);
      x0 = i_req0_vld && !o_req0_busy;
      x1 = i_req1_vld && !o_req1_busy;
      xr = i_result_vld && !o_result_busy;
      @(posedge i_clk); #1;
      if (x0 && src0.size() > 0) void'(src0.pop_front());
      if (x1 && src1.size() > 0) void'(src1.pop_front());
      if (xr && res_q.size() > 0) void'(res_q.pop_front());
      i_req0_vld    = src0.size() > 0;
      i_req0_data   = (src0.size() > 0) ? src0[0] : 24'h0;
      i_req1_vld    = src1.size() > 0;
      i_req1_data   = (src1.size() > 0) ? src1[0] : 24'h0;
      i_result_vld  = res_en && res_q.size() > 0;
      i_result_data = (res_q.size() > 0) ? res_q[0] : 24'h0;
    end
  end

  always @(negedge i_clk) begin
    cyc++;
    if (i_rst && o_rgb_vld && !i_rgb_busy) begin
      checks++;
      rgb_cnt++;
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
      if (exp_rgb.size() == 0) begin
        failures++; $display("FAIL rgb_extra got=%h expected=none", o_rgb_data);
      end else begin
        mon_e = exp_rgb.pop_front();
        if (o_rgb_data !== mon_e) begin
          failures++; $display("FAIL rgb_data got=%h expected=%h", o_rgb_data, mon_e);
        end
      end
    end
    if (i_rst && o_rsp0_vld && !i_rsp0_busy) begin
      checks++;
      if (exp_rsp0.size() == 0) begin
        failures++; $display("FAIL rsp0_extra got=%h expected=none", o_rsp0_data);
      end else begin
        mon_e = exp_rsp0.pop_front();
        if (o_rsp0_data !== mon_e) begin
          failures++; $display("FAIL rsp0_data got=%h expected=%h", o_rsp0_data, mon_e);
        end
      end
    end
    if (i_rst && o_rsp1_vld && !i_rsp1_busy) begin
      checks++;
      if (exp_rsp1.size() == 0) begin
        failures++; $display("FAIL rsp1_extra got=%h expected=none", o_rsp1_data);
      end else begin
        mon_e = exp_rsp1.pop_front();
        if (o_rsp1_data !== mon_e) begin
          failures++; $display("FAIL rsp1_data got=%h expected=%h", o_rsp1_data, mon_e);
        end
      end
    end
  end

  task automatic push_frame(input int r, input logic [23:0] base, input logic [23:0] res);
    for (int i = 0; i < 9; i++) begin
      if (r == 0) src0.push_back(base + 24'(i)); else src1.push_back(base + 24'(i));
      exp_rgb.push_back(base + 24'(i));
    end
    res_q.push_back(res);
    if (r == 0) exp_rsp0.push_back(res); else exp_rsp1.push_back(res);
  endtask

  task automatic wait_frames(input logic [15:0] target, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge i_clk); #1;
      ok = (o_frames_done == target);
    end
  endtask

  task automatic wait_rgb_left(input int left, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge i_clk); #1;
      ok = (exp_rgb.size() == left);
    end
  endtask

  task automatic wait_rgb_vld(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge i_clk); #1;
      ok = o_rgb_vld;
    end
  endtask

  task automatic apply_reset();
    @(posedge i_clk); #3;
    i_rst = 1'b0;
    src0.delete(); src1.delete(); res_q.delete();
    exp_rgb.delete(); exp_rsp0.delete(); exp_rsp1.delete();
    res_en = 1'b0; i_rgb_busy = 1'b0; i_rsp0_busy = 1'b0; i_rsp1_busy = 1'b0;
    repeat (2) @(posedge i_clk);
    #3 i_rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge i_clk); #1;
    checks++; if (o_grant !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b expected=00", o_grant); end
    checks++; if (o_frames_done !== 16'd0) begin failures++; $display("FAIL reset_frames got=%0d expected=0", o_frames_done); end
    checks++; if ({o_req0_busy, o_req1_busy, o_result_busy} !== 3'b111) begin failures++; $display("FAIL reset_busy got=%b expected=111", {o_req0_busy, o_req1_busy, o_result_busy}); end
    checks++; if ({o_rgb_vld, o_rsp0_vld, o_rsp1_vld} !== 3'b000) begin failures++; $display("FAIL reset_vld got=%b expected=000", {o_rgb_vld, o_rsp0_vld, o_rsp1_vld}); end
    @(posedge i_clk); #3 i_rst = 1'b1;
  endtask

  task automatic test_single_frame();
    bit ok; int base;
    base = rgb_cnt; first_cyc = -1;
    push_frame(0, 24'h100000, 24'hA0A0A0);
    wait_rgb_vld(ok);
    checks++; if (!ok || o_grant !== 2'b01) begin failures++; $display("FAIL single_grant got=%b expected=01 ok=%0b", o_grant, ok); end
    wait_rgb_left(0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_feed_timeout got=%0d expected=0 left", exp_rgb.size()); end
    checks++; if (last_cyc - first_cyc + 1 != 9) begin failures++; $display("FAIL single_span got=%0d expected=9", last_cyc - first_cyc + 1); end
    @(negedge i_clk); #1;
    checks++; if (o_req0_busy !== 1'b1 || o_frames_done !== 16'd0) begin failures++; $display("FAIL single_drain got=busy%b/%0d expected=busy1/0", o_req0_busy, o_frames_done); end
    res_en = 1'b1;
    wait_frames(16'd1, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_done got=%0d expected=1", o_frames_done); end
    checks++; if (o_grant !== 2'b00) begin failures++; $display("FAIL single_grant_idle got=%b expected=00", o_grant); end
    checks++; if (rgb_cnt - base != 9 || exp_rsp0.size() != 0) begin failures++; $display("FAIL single_counts got=%0d/%0d expected=9/0", rgb_cnt - base, exp_rsp0.size()); end
  endtask

  task automatic test_both_requesters();
    bit ok;
    apply_reset();
    push_frame(0, 24'h200000, 24'hB00001);
    push_frame(1, 24'h300000, 24'hB00002);
    res_en = 1'b1;
    wait_rgb_left(9, ok);
    checks++; if (!ok) begin failures++; $display("FAIL both_first_timeout got=%0d expected=9 left", exp_rgb.size()); end
    @(negedge i_clk); #1;
    checks++; if (o_frames_done !== 16'd1) begin failures++; $display("FAIL both_feed_to_idle got=%0d expected=1", o_frames_done); end
    checks++; if (o_result_busy !== 1'b1 || o_rsp1_vld !== 1'b0) begin failures++; $display("FAIL both_idle_bp got=%b%b expected=10", o_result_busy, o_rsp1_vld); end
    wait_rgb_vld(ok);
    checks++; if (!ok || o_grant !== 2'b10) begin failures++; $display("FAIL both_grant2 got=%b expected=10", o_grant); end
    wait_frames(16'd2, ok);
    checks++; if (!ok || exp_rsp0.size() != 0 || exp_rsp1.size() != 0) begin failures++; $display("FAIL both_done got=%0d expected=2", o_frames_done); end
    res_en = 1'b0;
  endtask

  task automatic test_rgb_stall();
    bit ok; int base;
    base = rgb_cnt;
    push_frame(0, 24'h400000, 24'hC00001);
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin @(negedge i_clk); #1; ok = (rgb_cnt - base == 4); end
    @(posedge i_clk); #2 i_rgb_busy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk); #1;
      checks++; if (o_req0_busy !== 1'b1 || o_rgb_vld !== 1'b1) begin failures++; $display("FAIL stall_busy%0d got=%b%b expected=11", c, o_req0_busy, o_rgb_vld); end
    end
    @(posedge i_clk); #2 i_rgb_busy = 1'b0;
    res_en = 1'b1;
    wait_frames(16'd3, ok);
    checks++; if (!ok || rgb_cnt - base != 9) begin failures++; $display("FAIL stall_count got=%0d expected=9", rgb_cnt - base); end
    res_en = 1'b0;
  endtask

  task automatic test_rsp_busy();
    bit ok;
    i_rsp0_busy = 1'b1;
    push_frame(0, 24'h500000, 24'hD00001);
    res_en = 1'b1;
    wait_rgb_left(0, ok);
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk); #1;
      checks++;
      if (o_result_busy !== 1'b1 || o_rsp0_vld !== 1'b1 || o_rsp0_data !== 24'hD00001 || o_frames_done !== 16'd3) begin
        failures++; $display("FAIL rsp_hold%0d got=%b%b %h %0d expected=11 d00001 3", c, o_result_busy, o_rsp0_vld, o_rsp0_data, o_frames_done);
      end
    end
    @(posedge i_clk); #2 i_rsp0_busy = 1'b0;
    wait_frames(16'd4, ok);
    checks++; if (!ok || exp_rsp0.size() != 0) begin failures++; $display("FAIL rsp_release got=%0d expected=4", o_frames_done); end
    res_en = 1'b0;
  endtask

  task automatic test_reset_midframe();
    bit ok; int base;
    for (int i = 0; i < 4; i++) begin src0.push_back(24'h600000 + 24'(i)); exp_rgb.push_back(24'h600000 + 24'(i)); end
    wait_rgb_left(0, ok);
    @(negedge i_clk); #1;
    checks++; if (o_grant !== 2'b01 || o_req0_busy !== 1'b0) begin failures++; $display("FAIL mid_feed got=%b%b expected=010", o_grant, o_req0_busy); end
    @(posedge i_clk); #3 i_rst = 1'b0;
    #1;
    checks++; if (o_grant !== 2'b00 || o_frames_done !== 16'd0 || o_req0_busy !== 1'b1) begin failures++; $display("FAIL mid_reset got=%b %0d %b expected=00 0 1", o_grant, o_frames_done, o_req0_busy); end
    checks++; if (dut.r_in_cnt !== '0 || dut.r_out_cnt !== '0) begin failures++; $display("FAIL mid_cnt got=%0d/%0d expected=0/0", dut.r_in_cnt, dut.r_out_cnt); end
    @(posedge i_clk); #3 i_rst = 1'b1;
    base = rgb_cnt;
    push_frame(0, 24'h700000, 24'hE00001);
    res_en = 1'b1;
    wait_frames(16'd1, ok);
    checks++; if (!ok || rgb_cnt - base != 9) begin failures++; $display("FAIL mid_next got=%0d expected=9", rgb_cnt - base); end
    res_en = 1'b0;
  endtask

  task automatic test_wrap();
    bit ok;
    @(posedge i_clk); #3;
    force dut.r_frames_done = 16'hFFFF;
    #1 release dut.r_frames_done;
    @(negedge i_clk); #1;
    checks++; if (o_frames_done !== 16'hFFFF) begin failures++; $display("FAIL wrap_pre got=%h expected=ffff", o_frames_done); end
    push_frame(1, 24'h800000, 24'hF00001);
    res_en = 1'b1;
    wait_frames(16'd0, ok);
    checks++; if (!ok || exp_rsp1.size() != 0) begin failures++; $display("FAIL wrap got=%h expected=0000", o_frames_done); end
    res_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_both_requesters();
    test_rgb_stall();
    test_rsp_busy();
    test_reset_midframe();
    test_wrap();
    repeat (3) @(posedge i_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
